// File: rtl/holy_axi_slice.sv
// holy_axi_slice: AXI4 register slice with outstanding-transaction tracking.
//
// Every channel (AW, W, AR core->fabric; B, R fabric->core) passes through its
// own two-entry skid buffer. Each buffer has one cycle of forward latency and
// one beat per cycle of throughput. Its upstream ready comes straight from a
// flop, so no combinational path runs from a downstream ready to an upstream
// ready.
//
// rd_outst / wr_outst count reads and writes in flight. A read counts from the
// AR handshake until the R handshake with rlast. A write counts from the AW
// handshake until the B handshake. When a counter reaches MAX_OUTST, the
// matching address-channel ready is held low.
//
// Ports:
//   aclk, aresetn       clock, synchronous active-low reset
//   s_axi_*             core-side AXI slave port
//   m_axi_*             fabric-side AXI master port
//   rd_outst, wr_outst  reads / writes in flight
//
// Optional build macro HOLY_AXI_SLICE_STATS_EN adds three outputs:
//   rd_beats, wr_beats  fabric-side R / W handshake counters (wrap at 2^32)
//   max_rd_outst        high-watermark of rd_outst

module holy_axi_slice_skid #(
    parameter int W = 8
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic         main_valid;
    logic         skid_valid;
    logic [W-1:0] main_data;
    logic [W-1:0] skid_data;
    logic         in_hs;
    logic         out_hs;

    assign in_hs     = in_valid && in_ready;
    assign out_hs    = main_valid && out_ready;
    assign out_valid = main_valid;
    assign out_data  = main_data;

    // Payload registers are deliberately left out of reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b0;
        end else begin
            if (!main_valid || out_hs) begin
                // Main is free this cycle. The skid entry is older than
                // anything new, so it moves up first. While skid is full,
                // in_ready is low, so no new beat can arrive in that case.
                if (skid_valid) begin
                    main_valid <= 1'b1;
                    main_data  <= skid_data;
                    skid_valid <= 1'b0;
                end else begin
                    main_valid <= in_hs;
                    if (in_hs) begin
                        main_data <= in_data;
                    end
                end
                in_ready <= 1'b1;
            end else if (in_hs) begin
                skid_valid <= 1'b1;
                skid_data  <= in_data;
                in_ready   <= 1'b0;
            end else begin
                in_ready <= !skid_valid;
            end
        end
    end
endmodule

module holy_axi_slice #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ID_W      = 4,
    parameter int MAX_OUTST = 8
) (
    input  logic                      aclk,
    input  logic                      aresetn,

    input  logic [ID_W-1:0]           s_axi_awid,
    input  logic [ADDR_W-1:0]         s_axi_awaddr,
    input  logic [7:0]                s_axi_awlen,
    input  logic [2:0]                s_axi_awsize,
    input  logic [1:0]                s_axi_awburst,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [DATA_W-1:0]         s_axi_wdata,
    input  logic [DATA_W/8-1:0]       s_axi_wstrb,
    input  logic                      s_axi_wlast,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    output logic [ID_W-1:0]           s_axi_bid,
    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    input  logic [ID_W-1:0]           s_axi_arid,
    input  logic [ADDR_W-1:0]         s_axi_araddr,
    input  logic [7:0]                s_axi_arlen,
    input  logic [2:0]                s_axi_arsize,
    input  logic [1:0]                s_axi_arburst,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    output logic [ID_W-1:0]           s_axi_rid,
    output logic [DATA_W-1:0]         s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rlast,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,

    output logic [ID_W-1:0]           m_axi_awid,
    output logic [ADDR_W-1:0]         m_axi_awaddr,
    output logic [7:0]                m_axi_awlen,
    output logic [2:0]                m_axi_awsize,
    output logic [1:0]                m_axi_awburst,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [DATA_W-1:0]         m_axi_wdata,
    output logic [DATA_W/8-1:0]       m_axi_wstrb,
    output logic                      m_axi_wlast,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [ID_W-1:0]           m_axi_bid,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    output logic [ID_W-1:0]           m_axi_arid,
    output logic [ADDR_W-1:0]         m_axi_araddr,
    output logic [7:0]                m_axi_arlen,
    output logic [2:0]                m_axi_arsize,
    output logic [1:0]                m_axi_arburst,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [ID_W-1:0]           m_axi_rid,
    input  logic [DATA_W-1:0]         m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rlast,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready,

    output logic [$clog2(MAX_OUTST):0] rd_outst,
`ifdef HOLY_AXI_SLICE_STATS_EN
    output logic [31:0]               rd_beats,
    output logic [31:0]               wr_beats,
    output logic [$clog2(MAX_OUTST):0] max_rd_outst,
`endif
    output logic [$clog2(MAX_OUTST):0] wr_outst
);
    localparam int CW = $clog2(MAX_OUTST) + 1;
    localparam int AX_W = ID_W + ADDR_W + 13;
    localparam int W_W  = DATA_W + DATA_W/8 + 1;
    localparam int B_W  = ID_W + 2;
    localparam int R_W  = ID_W + DATA_W + 3;
    localparam logic [CW-1:0] OUTST_FULL = CW'(MAX_OUTST);
    localparam logic [CW-1:0] ONE        = CW'(1);

    logic          aw_skid_ready;
    logic          ar_skid_ready;
    logic          wr_full;
    logic          rd_full;
    logic          ar_hs;
    logic          r_done;
    logic          aw_hs;
    logic          b_done;
    logic [CW-1:0] rd_outst_nxt;
    logic [CW-1:0] wr_outst_nxt;

    assign wr_full = (wr_outst == OUTST_FULL);
    assign rd_full = (rd_outst == OUTST_FULL);

    // Limit gating sits after the skid ready. The same term masks the valid
    // going into the buffer, so the buffer only sees beats that really
    // handshake on the core side.
    assign s_axi_awready = aw_skid_ready && !wr_full;
    assign s_axi_arready = ar_skid_ready && !rd_full;

    holy_axi_slice_skid #(.W(AX_W)) u_aw (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .in_valid  (s_axi_awvalid && !wr_full),
        .in_ready  (aw_skid_ready),
        .in_data   ({s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst}),
        .out_valid (m_axi_awvalid),
        .out_ready (m_axi_awready),
        .out_data  ({m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst})
    );

    holy_axi_slice_skid #(.W(W_W)) u_w (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .in_valid  (s_axi_wvalid),
        .in_ready  (s_axi_wready),
        .in_data   ({s_axi_wdata, s_axi_wstrb, s_axi_wlast}),
        .out_valid (m_axi_wvalid),
        .out_ready (m_axi_wready),
        .out_data  ({m_axi_wdata, m_axi_wstrb, m_axi_wlast})
    );

    holy_axi_slice_skid #(.W(B_W)) u_b (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .in_valid  (m_axi_bvalid),
        .in_ready  (m_axi_bready),
        .in_data   ({m_axi_bid, m_axi_bresp}),
        .out_valid (s_axi_bvalid),
        .out_ready (s_axi_bready),
        .out_data  ({s_axi_bid, s_axi_bresp})
    );

    holy_axi_slice_skid #(.W(AX_W)) u_ar (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .in_valid  (s_axi_arvalid && !rd_full),
        .in_ready  (ar_skid_ready),
        .in_data   ({s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst}),
        .out_valid (m_axi_arvalid),
        .out_ready (m_axi_arready),
        .out_data  ({m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst})
    );

    holy_axi_slice_skid #(.W(R_W)) u_r (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .in_valid  (m_axi_rvalid),
        .in_ready  (m_axi_rready),
        .in_data   ({m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast}),
        .out_valid (s_axi_rvalid),
        .out_ready (s_axi_rready),
        .out_data  ({s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast})
    );

    assign aw_hs  = s_axi_awvalid && s_axi_awready;
    assign b_done = s_axi_bvalid && s_axi_bready;
    assign ar_hs  = s_axi_arvalid && s_axi_arready;
    assign r_done = s_axi_rvalid && s_axi_rready && s_axi_rlast;

    // A simultaneous increment and decrement holds the count. A decrement at
    // zero comes from a protocol error upstream; the counter stays at zero
    // instead of wrapping.
    always_comb begin
        rd_outst_nxt = rd_outst;
        if (ar_hs && !r_done) begin
            rd_outst_nxt = rd_outst + ONE;
        end else if (r_done && !ar_hs && rd_outst != '0) begin
            rd_outst_nxt = rd_outst - ONE;
        end

        wr_outst_nxt = wr_outst;
        if (aw_hs && !b_done) begin
            wr_outst_nxt = wr_outst + ONE;
        end else if (b_done && !aw_hs && wr_outst != '0) begin
            wr_outst_nxt = wr_outst - ONE;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rd_outst <= '0;
            wr_outst <= '0;
        end else begin
            rd_outst <= rd_outst_nxt;
            wr_outst <= wr_outst_nxt;
        end
    end

`ifdef HOLY_AXI_SLICE_STATS_EN
    // The watermark follows the next count, so it never lags rd_outst.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rd_beats     <= '0;
            wr_beats     <= '0;
            max_rd_outst <= '0;
        end else begin
            if (m_axi_rvalid && m_axi_rready) begin
                rd_beats <= rd_beats + 32'd1;
            end
            if (m_axi_wvalid && m_axi_wready) begin
                wr_beats <= wr_beats + 32'd1;
            end
            if (rd_outst_nxt > max_rd_outst) begin
                max_rd_outst <= rd_outst_nxt;
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_holy_axi_slice.sv
module tb_holy_axi_slice;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int ID_W      = 4;
    localparam int MAX_OUTST = 8;
    localparam int CW        = 4;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    logic [ID_W-1:0] s_axi_awid, m_axi_awid, s_axi_arid, m_axi_arid;
    logic [ADDR_W-1:0] s_axi_awaddr, m_axi_awaddr, s_axi_araddr, m_axi_araddr;
    logic [7:0] s_axi_awlen, m_axi_awlen, s_axi_arlen, m_axi_arlen;
    logic [2:0] s_axi_awsize, m_axi_awsize, s_axi_arsize, m_axi_arsize;
    logic [1:0] s_axi_awburst, m_axi_awburst, s_axi_arburst, m_axi_arburst;
    logic s_axi_awvalid, s_axi_awready, m_axi_awvalid, m_axi_awready;
    logic s_axi_arvalid, s_axi_arready, m_axi_arvalid, m_axi_arready;
    logic [DATA_W-1:0] s_axi_wdata, m_axi_wdata, s_axi_rdata, m_axi_rdata;
    logic [DATA_W/8-1:0] s_axi_wstrb, m_axi_wstrb;
    logic s_axi_wlast, m_axi_wlast, s_axi_wvalid, m_axi_wvalid, s_axi_wready, m_axi_wready;
    logic [ID_W-1:0] s_axi_bid, m_axi_bid, s_axi_rid, m_axi_rid;
    logic [1:0] s_axi_bresp, m_axi_bresp, s_axi_rresp, m_axi_rresp;
    logic s_axi_bvalid, m_axi_bvalid, s_axi_bready, m_axi_bready;
    logic s_axi_rlast, m_axi_rlast, s_axi_rvalid, m_axi_rvalid, s_axi_rready, m_axi_rready;
    logic [CW-1:0] rd_outst, wr_outst;
`ifdef HOLY_AXI_SLICE_STATS_EN
    logic [31:0] rd_beats, wr_beats;
    logic [CW-1:0] max_rd_outst;
`endif

    holy_axi_slice #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .MAX_OUTST(MAX_OUTST)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .rd_outst(rd_outst),
`ifdef HOLY_AXI_SLICE_STATS_EN
        .rd_beats(rd_beats), .wr_beats(wr_beats), .max_rd_outst(max_rd_outst),
`endif
        .wr_outst(wr_outst)
    );

    // Generic channel view: 0 AW, 1 W, 2 AR (core->fabric), 3 B, 4 R (fabric->core)
    logic        drv_valid [5];
    logic [63:0] drv_data  [5];
    logic        drv_ready [5];
    logic        obs_in_ready [5];
    logic        obs_valid [5];
    logic [63:0] obs_data [5];

    assign s_axi_awvalid = drv_valid[0];
    assign {s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst} = drv_data[0][48:0];
    assign m_axi_awready = drv_ready[0];
    assign obs_in_ready[0] = s_axi_awready;
    assign obs_valid[0] = m_axi_awvalid;
    assign obs_data[0] = {15'd0, m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst};

    assign s_axi_wvalid = drv_valid[1];
    assign {s_axi_wdata, s_axi_wstrb, s_axi_wlast} = drv_data[1][36:0];
    assign m_axi_wready = drv_ready[1];
    assign obs_in_ready[1] = s_axi_wready;
    assign obs_valid[1] = m_axi_wvalid;
    assign obs_data[1] = {27'd0, m_axi_wdata, m_axi_wstrb, m_axi_wlast};

    assign s_axi_arvalid = drv_valid[2];
    assign {s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst} = drv_data[2][48:0];
    assign m_axi_arready = drv_ready[2];
    assign obs_in_ready[2] = s_axi_arready;
    assign obs_valid[2] = m_axi_arvalid;
    assign obs_data[2] = {15'd0, m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst};

    assign m_axi_bvalid = drv_valid[3];
    assign {m_axi_bid, m_axi_bresp} = drv_data[3][5:0];
    assign s_axi_bready = drv_ready[3];
    assign obs_in_ready[3] = m_axi_bready;
    assign obs_valid[3] = s_axi_bvalid;
    assign obs_data[3] = {58'd0, s_axi_bid, s_axi_bresp};

    assign m_axi_rvalid = drv_valid[4];
    assign {m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast} = drv_data[4][38:0];
    assign s_axi_rready = drv_ready[4];
    assign obs_in_ready[4] = m_axi_rready;
    assign obs_valid[4] = s_axi_rvalid;
    assign obs_data[4] = {25'd0, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast};

    // Reference model: each channel is a two-deep FIFO; counters follow the
    // handshake rules directly.
    logic [63:0] mq [5][2];
    int          mn [5];
    int          m_rd, m_wr, m_rd_beats, m_wr_beats, m_max_rd;
    bit          m_rst = 1'b1;
    logic [63:0] w_seen [$];

    int checks = 0;
    int errors = 0;

    function automatic bit exp_ready(int c);
        if (m_rst) return 1'b0;
        if (mn[c] >= 2) return 1'b0;
        if (c == 0 && m_wr >= MAX_OUTST) return 1'b0;
        if (c == 2 && m_rd >= MAX_OUTST) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [63:0] chmask(int c);
        int w;
        case (c)
            0, 2:    w = 49;
            1:       w = 37;
            3:       w = 6;
            default: w = 39;
        endcase
        return (64'd1 << w) - 64'd1;
    endfunction

    function automatic logic [63:0] rnd(int c);
        return {$urandom, $urandom} & chmask(c);
    endfunction

    task automatic idle();
        for (int c = 0; c < 5; c++) begin
            drv_valid[c] = 1'b0;
            drv_data[c]  = 64'd0;
            drv_ready[c] = 1'b1;
        end
    endtask

    task automatic step();
        bit ihs [5];
        bit ohs [5];
        logic [63:0] din [5];
        bit ar_inc, r_dec, aw_inc, b_dec;
        for (int c = 0; c < 5; c++) begin
            ihs[c] = drv_valid[c] && exp_ready(c);
            ohs[c] = (mn[c] > 0) && drv_ready[c];
            din[c] = drv_data[c];
        end
        aw_inc = ihs[0];
        ar_inc = ihs[2];
        b_dec  = ohs[3];
        r_dec  = ohs[4] && mq[4][0][0];
        @(posedge aclk);
        if (!aresetn) begin
            for (int c = 0; c < 5; c++) mn[c] = 0;
            m_rd = 0; m_wr = 0; m_rd_beats = 0; m_wr_beats = 0; m_max_rd = 0;
            m_rst = 1'b1;
        end else begin
            m_rst = 1'b0;
            if (ohs[1]) w_seen.push_back(mq[1][0]);
            if (ihs[4]) m_rd_beats++;
            if (ohs[1]) m_wr_beats++;
            for (int c = 0; c < 5; c++) begin
                if (ohs[c]) begin
                    mq[c][0] = mq[c][1];
                    mn[c]--;
                end
                if (ihs[c]) begin
                    mq[c][mn[c]] = din[c];
                    mn[c]++;
                end
            end
            if (ar_inc && !r_dec) m_rd++;
            else if (r_dec && !ar_inc && m_rd > 0) m_rd--;
            if (aw_inc && !b_dec) m_wr++;
            else if (b_dec && !aw_inc && m_wr > 0) m_wr--;
            if (m_rd > m_max_rd) m_max_rd = m_rd;
        end
        #1;
    endtask

    task automatic reset_dut();
        idle();
        aresetn = 1'b0;
        step();
        step();
        aresetn = 1'b1;
        step();
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        for (int c = 0; c < 5; c++) begin
            drv_valid[c] = 1'b1;
            drv_data[c]  = rnd(c);
            drv_ready[c] = 1'b1;
        end
        step();
        step();
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (obs_valid[c] !== 1'b0) begin
                errors++;
                $display("FAIL reset_valid ch%0d got %b exp 0", c, obs_valid[c]);
            end
            checks++;
            if (obs_in_ready[c] !== 1'b0) begin
                errors++;
                $display("FAIL reset_ready ch%0d got %b exp 0", c, obs_in_ready[c]);
            end
        end
        checks++;
        if (rd_outst !== 4'd0 || wr_outst !== 4'd0) begin
            errors++;
            $display("FAIL reset_counters got rd=%0d wr=%0d exp 0/0", rd_outst, wr_outst);
        end
        idle();
        aresetn = 1'b1;
        step();
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (obs_in_ready[c] !== 1'b1) begin
                errors++;
                $display("FAIL post_reset_ready ch%0d got %b exp 1", c, obs_in_ready[c]);
            end
        end
    endtask

    task automatic test_ar_latency();
        reset_dut();
        drv_valid[2] = 1'b1;
        drv_data[2]  = {15'd0, 4'h3, 32'h0000_1000, 8'd0, 3'd2, 2'd1};
        step();
        drv_valid[2] = 1'b0;
        checks++;
        if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 32'h0000_1000 || m_axi_arid !== 4'h3) begin
            errors++;
            $display("FAIL ar_latency got valid=%b addr=%h id=%h exp 1/00001000/3",
                     m_axi_arvalid, m_axi_araddr, m_axi_arid);
        end
        checks++;
        if (rd_outst !== 4'd1) begin
            errors++;
            $display("FAIL ar_outst got %0d exp 1", rd_outst);
        end
    endtask

    task automatic test_w_stall();
        int  k;
        bit  acc;
        logic exp_w;
        reset_dut();
        w_seen.delete();
        k = 0;
        for (int cyc = 0; cyc < 40 && w_seen.size() < 8; cyc++) begin
            drv_valid[1] = (k < 8);
            drv_data[1]  = {27'd0, 32'(k), 4'hF, (k == 7)};
            drv_ready[1] = !(cyc >= 2 && cyc <= 4);
            if (cyc == 2 || cyc == 3) begin
                exp_w = (cyc == 2);
                checks++;
                if (s_axi_wready !== exp_w) begin
                    errors++;
                    $display("FAIL w_stall_drop cyc%0d got %b exp %b", cyc, s_axi_wready, exp_w);
                end
            end
            checks++;
            if (s_axi_wready !== exp_ready(1)) begin
                errors++;
                $display("FAIL w_stall_ready cyc%0d got %b exp %b", cyc, s_axi_wready, exp_ready(1));
            end
            acc = drv_valid[1] && exp_ready(1);
            step();
            if (acc) k++;
        end
        drv_valid[1] = 1'b0;
        checks++;
        if (w_seen.size() != 8) begin
            errors++;
            $display("FAIL w_stall_count got %0d exp 8", w_seen.size());
        end
        for (int i = 0; i < w_seen.size(); i++) begin
            checks++;
            if (w_seen[i][36:5] !== 32'(i)) begin
                errors++;
                $display("FAIL w_stall_order beat%0d got %0d exp %0d", i, w_seen[i][36:5], i);
            end
        end
    endtask

    task automatic test_outst_limit();
        reset_dut();
        drv_valid[2] = 1'b1;
        drv_data[2]  = rnd(2);
        for (int cyc = 0; cyc < 40 && m_rd < 8; cyc++) step();
        checks++;
        if (s_axi_arready !== 1'b0 || rd_outst !== 4'd8) begin
            errors++;
            $display("FAIL limit_full got arready=%b rd=%0d exp 0/8", s_axi_arready, rd_outst);
        end
        step();
        checks++;
        if (s_axi_arready !== 1'b0) begin
            errors++;
            $display("FAIL limit_hold got arready=%b exp 0", s_axi_arready);
        end
        drv_valid[4] = 1'b1;
        drv_data[4]  = rnd(4) | 64'd1;
        step();
        drv_valid[4] = 1'b0;
        checks++;
        if (s_axi_arready !== 1'b0 || s_axi_rvalid !== 1'b1) begin
            errors++;
            $display("FAIL limit_r_in got arready=%b rvalid=%b exp 0/1", s_axi_arready, s_axi_rvalid);
        end
        step();
        checks++;
        if (s_axi_arready !== 1'b1 || rd_outst !== 4'd7) begin
            errors++;
            $display("FAIL limit_release got arready=%b rd=%0d exp 1/7", s_axi_arready, rd_outst);
        end
        step();
        drv_valid[2] = 1'b0;
        checks++;
        if (s_axi_arready !== 1'b0 || rd_outst !== 4'd8) begin
            errors++;
            $display("FAIL limit_refill got arready=%b rd=%0d exp 0/8", s_axi_arready, rd_outst);
        end
    endtask

    task automatic test_simultaneous();
        reset_dut();
        drv_valid[2] = 1'b1;
        drv_data[2]  = rnd(2);
        step(); step(); step();
        drv_valid[2] = 1'b0;
        drv_ready[4] = 1'b0;
        drv_valid[4] = 1'b1;
        drv_data[4]  = rnd(4) | 64'd1;
        step();
        drv_valid[4] = 1'b0;
        checks++;
        if (rd_outst !== 4'd3 || s_axi_rvalid !== 1'b1) begin
            errors++;
            $display("FAIL simul_setup got rd=%0d rvalid=%b exp 3/1", rd_outst, s_axi_rvalid);
        end
        drv_valid[2] = 1'b1;
        drv_data[2]  = rnd(2);
        drv_ready[4] = 1'b1;
        step();
        drv_valid[2] = 1'b0;
        checks++;
        if (rd_outst !== 4'd3 || s_axi_rvalid !== 1'b0 || m_axi_arvalid !== 1'b1) begin
            errors++;
            $display("FAIL simul_hold got rd=%0d rvalid=%b arvalid=%b exp 3/0/1",
                     rd_outst, s_axi_rvalid, m_axi_arvalid);
        end
    endtask

    task automatic test_reset_mid();
        reset_dut();
        drv_valid[0] = 1'b1;
        drv_data[0]  = rnd(0);
        step(); step();
        drv_valid[0] = 1'b0;
        checks++;
        if (wr_outst !== 4'd2) begin
            errors++;
            $display("FAIL midrst_setup got wr=%0d exp 2", wr_outst);
        end
        drv_ready[3] = 1'b0;
        drv_valid[3] = 1'b1;
        drv_data[3]  = rnd(3);
        step();
        drv_data[3]  = rnd(3);
        step();
        drv_valid[3] = 1'b0;
        checks++;
        if (s_axi_bvalid !== 1'b1 || m_axi_bready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_buffered got bvalid=%b bready=%b exp 1/0", s_axi_bvalid, m_axi_bready);
        end
        aresetn = 1'b0;
        step();
        aresetn = 1'b1;
        drv_ready[3] = 1'b1;
        checks++;
        if (s_axi_bvalid !== 1'b0 || wr_outst !== 4'd0) begin
            errors++;
            $display("FAIL midrst_clear got bvalid=%b wr=%0d exp 0/0", s_axi_bvalid, wr_outst);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (s_axi_bvalid !== 1'b0) begin
                errors++;
                $display("FAIL midrst_stale cyc%0d got bvalid=%b exp 0", i, s_axi_bvalid);
            end
        end
    endtask

    task automatic test_random();
        int lastp;
        int rdyp;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            lastp = (cyc < 1500) ? 8 : 2;
            rdyp  = (cyc < 1500) ? 2 : 4;
            aresetn = ($urandom_range(0, 299) != 0);
            for (int c = 0; c < 5; c++) begin
                drv_valid[c] = ($urandom_range(0, 3) != 0);
                drv_data[c]  = rnd(c);
                drv_ready[c] = ($urandom_range(0, rdyp - 1) != 0);
            end
            if (cyc < 1500) drv_valid[3] = ($urandom_range(0, 7) == 0);
            drv_data[4][0] = ($urandom_range(0, lastp - 1) == 0);
            step();
            for (int c = 0; c < 5; c++) begin
                checks++;
                if (obs_in_ready[c] !== exp_ready(c)) begin
                    errors++;
                    $display("FAIL rand_ready ch%0d cyc%0d got %b exp %b", c, cyc, obs_in_ready[c], exp_ready(c));
                end
                checks++;
                if (obs_valid[c] !== logic'(mn[c] > 0)) begin
                    errors++;
                    $display("FAIL rand_valid ch%0d cyc%0d got %b exp %b", c, cyc, obs_valid[c], mn[c] > 0);
                end
                if (mn[c] > 0) begin
                    checks++;
                    if (obs_data[c] !== mq[c][0]) begin
                        errors++;
                        $display("FAIL rand_data ch%0d cyc%0d got %h exp %h", c, cyc, obs_data[c], mq[c][0]);
                    end
                end
            end
            checks++;
            if (rd_outst !== CW'(m_rd) || wr_outst !== CW'(m_wr)) begin
                errors++;
                $display("FAIL rand_outst cyc%0d got rd=%0d wr=%0d exp %0d/%0d", cyc, rd_outst, wr_outst, m_rd, m_wr);
            end
`ifdef HOLY_AXI_SLICE_STATS_EN
            checks++;
            if (rd_beats !== 32'(m_rd_beats) || wr_beats !== 32'(m_wr_beats) || max_rd_outst !== CW'(m_max_rd)) begin
                errors++;
                $display("FAIL rand_stats cyc%0d got %0d/%0d/%0d exp %0d/%0d/%0d", cyc,
                         rd_beats, wr_beats, max_rd_outst, m_rd_beats, m_wr_beats, m_max_rd);
            end
`endif
        end
        aresetn = 1'b1;
        idle();
    endtask

`ifdef HOLY_AXI_SLICE_STATS_EN
    task automatic test_stats();
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            drv_valid[4] = 1'b1;
            drv_data[4]  = (rnd(4) & ~64'd1) | 64'(i == 3);
            step();
        end
        drv_valid[4] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drv_valid[1] = 1'b1;
            drv_data[1]  = rnd(1);
            step();
        end
        drv_valid[1] = 1'b0;
        step();
        step();
        checks++;
        if (rd_beats !== 32'd4 || wr_beats !== 32'd2) begin
            errors++;
            $display("FAIL stats_beats got rd=%0d wr=%0d exp 4/2", rd_beats, wr_beats);
        end
        checks++;
        if (max_rd_outst !== 4'd0) begin
            errors++;
            $display("FAIL stats_watermark got %0d exp 0", max_rd_outst);
        end
    endtask
`endif

    initial begin
        idle();
        test_reset();
        test_ar_latency();
        test_w_stall();
        test_outst_limit();
        test_simultaneous();
        test_reset_mid();
        test_random();
`ifdef HOLY_AXI_SLICE_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
